// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// word alignment constants.
package fetch_pkg;

    // Low address bits that must be zero for a word-aligned fetch.
    localparam int ALIGN_BITS = 2;

    // Bytes per instruction word; the PC advances by this amount per pc_inc.
    localparam int WORD_BYTES = 4;

    // Fetch FSM states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,  // sample pc_addr and start a fetch
        S_REQ  = 3'd1,  // request presented, waiting for grant
        S_WAIT = 3'd2,  // granted, waiting for read data
        S_HOLD = 3'd3,  // word presented to decoder, waiting for ready
        S_DROP = 3'd4,  // flushed while data outstanding, absorb it
        S_ERR  = 3'd5   // misaligned PC, stalled until flush
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one word per PC address over a req/gnt/rvalid
// memory bus, hands it to the decoder with valid/ready and pulses pc_inc on
// acceptance. A flush (issued with a PC jump) discards any in-flight or held
// fetch; a read already granted is absorbed in DROP so the bus never carries
// more than one outstanding request.
module instr_fetch #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int ALIGN_BITS = fetch_pkg::ALIGN_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_inc,
    input  logic          flush,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          instr_valid,
    output logic [DW-1:0] instr_data,
    input  logic          instr_ready,
    output logic          fetch_err
);

    import fetch_pkg::*;

    fetch_state_e  state_q;
    logic          mem_req_q;
    logic          instr_valid_q;
    logic          fetch_err_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] instr_data_q;
    logic          pc_misaligned_s;

    assign pc_misaligned_s = (pc_addr[ALIGN_BITS-1:0] != '0);

    // Fetch FSM with its registered outputs and address/data capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            mem_addr_q    <= '0;
            instr_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else if (pc_misaligned_s) begin
                        state_q     <= S_ERR;
                        fetch_err_q <= 1'b1;
                    end else begin
                        state_q    <= S_REQ;
                        mem_addr_q <= pc_addr;
                        mem_req_q  <= 1'b1;
                    end
                end
                S_REQ: begin
                    // A grant in a flush cycle is not taken: the request is withdrawn.
                    if (flush) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end else if (mem_gnt) begin
                        state_q   <= S_WAIT;
                        mem_req_q <= 1'b0;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (flush && !mem_rvalid) begin
                        state_q <= S_DROP;
                    end else if (flush) begin
                        state_q <= S_IDLE;
                    end else if (mem_rvalid) begin
                        state_q       <= S_HOLD;
                        instr_data_q  <= mem_rdata;
                        instr_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    // Flush wins over the handshake; pc_inc is masked by flush too.
                    if (flush || instr_ready) begin
                        state_q       <= S_IDLE;
                        instr_valid_q <= 1'b0;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if (mem_rvalid) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DROP;
                    end
                end
                S_ERR: begin
                    if (flush) begin
                        state_q     <= S_IDLE;
                        fetch_err_q <= 1'b0;
                    end else begin
                        state_q <= S_ERR;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    fetch_err_q   <= 1'b0;
                end
            endcase
        end
    end

    // PC advance is combinational so the PC moves on the same edge as the handshake.
    assign pc_inc      = (state_q == S_HOLD) && instr_ready && !flush;

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by randomized
// PC/memory/decoder traffic checked against a transaction-level model.
module tb_instr_fetch;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_addr;
    logic          pc_inc;
    logic          flush;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic          instr_ready;
    logic          fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.AW(AW), .DW(DW), .ALIGN_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pc_addr),
        .pc_inc     (pc_inc),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_ready(instr_ready),
        .fetch_err  (fetch_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory contents as a function of address.
    function automatic logic [31:0] word_of(input logic [7:0] a);
        return {~a, a, a ^ 8'hA5, a + 8'd7};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"},   32'(mem_req),     32'd0);
        check_val({tag, "_inc"},   32'(pc_inc),      32'd0);
        check_val({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check_val({tag, "_err"},   32'(fetch_err),   32'd0);
        check_val({tag, "_addr"},  32'(mem_addr),    32'd0);
        check_val({tag, "_data"},  instr_data,       32'd0);
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Random-phase model state.
        bit          outstanding;
        bit          live;
        bit          holding;
        logic [31:0] hold_data;
        logic [31:0] pend_data;
        int          lat;
        bit          do_flush;
        bit          exp_inc;
        bit          inc_seen;
        logic [7:0]  tgt;
        int          idle_cycles;
        int          n_inc;

        rst = 1'b1; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0; instr_ready = 1'b0; pc_addr = 8'h00;

        // 1: basic fetch at 0x00, rvalid two cycles after grant.
        tick(); tick();
        check_all_zero("t1_rst");
        rst = 1'b0;
        tick();
        check_val("t1_req", 32'(mem_req), 32'd1);
        check_val("t1_addr", 32'(mem_addr), 32'h00);
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        check_val("t1_req_off", 32'(mem_req), 32'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; tick();
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        check_val("t1_valid", 32'(instr_valid), 32'd1);
        check_val("t1_data", instr_data, 32'hDEADBEEF);
        instr_ready = 1'b1; #1;
        check_val("t1_inc", 32'(pc_inc), 32'd1);
        tick();
        instr_ready = 1'b0; pc_addr = pc_addr + 8'd4;
        check_val("t1_inc_once", 32'(pc_inc), 32'd0);
        check_val("t1_valid_off", 32'(instr_valid), 32'd0);
        tick();
        check_val("t1_next_req", 32'(mem_req), 32'd1);
        check_val("t1_next_addr", 32'(mem_addr), 32'h04);

        // 2: decoder stalls five cycles in HOLD.
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678; tick(); mem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("t2_valid", 32'(instr_valid), 32'd1);
            check_val("t2_data", instr_data, 32'h12345678);
            check_val("t2_inc", 32'(pc_inc), 32'd0);
            check_val("t2_req", 32'(mem_req), 32'd0);
            tick();
        end
        instr_ready = 1'b1; #1;
        check_val("t2_inc_on", 32'(pc_inc), 32'd1);
        tick();
        instr_ready = 1'b0; pc_addr = pc_addr + 8'd4;
        check_val("t2_inc_once", 32'(pc_inc), 32'd0);
        check_val("t2_valid_off", 32'(instr_valid), 32'd0);

        // 3: flush in WAIT, late rvalid absorbed in DROP, restart at jump target.
        tick();
        check_val("t3_addr", 32'(mem_addr), 32'h08);
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0; pc_addr = 8'h40;
        for (int i = 0; i < 2; i++) begin
            check_val("t3_drop_valid", 32'(instr_valid), 32'd0);
            check_val("t3_drop_req", 32'(mem_req), 32'd0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; tick(); mem_rvalid = 1'b0;
        check_val("t3_idle_valid", 32'(instr_valid), 32'd0);
        check_val("t3_idle_req", 32'(mem_req), 32'd0);
        tick();
        check_val("t3_req", 32'(mem_req), 32'd1);
        check_val("t3_new_addr", 32'(mem_addr), 32'h40);
        check_val("t3_no_valid", 32'(instr_valid), 32'd0);

        // 4: misaligned jump target stalls in ERR until the next flush.
        flush = 1'b1; tick(); flush = 1'b0; pc_addr = 8'h05;
        check_val("t4_req_off", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t4_err", 32'(fetch_err), 32'd1);
            check_val("t4_req", 32'(mem_req), 32'd0);
        end
        flush = 1'b1; tick(); flush = 1'b0; pc_addr = 8'h08;
        check_val("t4_err_off", 32'(fetch_err), 32'd0);
        tick();
        check_val("t4_req_on", 32'(mem_req), 32'd1);
        check_val("t4_addr", 32'(mem_addr), 32'h08);

        // 5: reset mid-WAIT clears outputs at once; late rvalid ignored.
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        tick();
        #2; rst = 1'b1; #1;
        check_all_zero("t5_async");
        pc_addr = 8'h00;
        tick();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        tick();
        mem_rvalid = 1'b0;
        check_val("t5_req", 32'(mem_req), 32'd1);
        check_val("t5_addr", 32'(mem_addr), 32'h00);
        check_val("t5_valid", 32'(instr_valid), 32'd0);
        check_val("t5_data", instr_data, 32'd0);

        // 6: flush and ready together in HOLD: no pc_inc, valid drops.
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; tick(); mem_rvalid = 1'b0;
        check_val("t6_valid", 32'(instr_valid), 32'd1);
        flush = 1'b1; instr_ready = 1'b1; #1;
        check_val("t6_inc", 32'(pc_inc), 32'd0);
        tick();
        flush = 1'b0; instr_ready = 1'b0; pc_addr = 8'h80;
        check_val("t6_valid_off", 32'(instr_valid), 32'd0);
        check_val("t6_inc_off", 32'(pc_inc), 32'd0);

        // Random traffic. DUT is in IDLE with nothing outstanding.
        outstanding = 1'b0; live = 1'b0; holding = 1'b0;
        hold_data = 32'd0; pend_data = 32'd0; lat = 0;
        idle_cycles = 0; n_inc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            do_flush = ($urandom_range(0, 99) < 4);
            tgt      = 8'($urandom) & 8'hFC;
            flush    = do_flush;
            mem_gnt  = mem_req && !do_flush && ($urandom_range(0, 99) < 60);
            if (outstanding && lat == 0) begin
                mem_rvalid = 1'b1; mem_rdata = pend_data;
            end else if (!outstanding && $urandom_range(0, 99) < 8) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
            end else begin
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
            instr_ready = ($urandom_range(0, 99) < 70);
            #1;
            exp_inc = holding && instr_ready && !do_flush;
            check_val("r_valid", 32'(instr_valid), 32'(holding));
            if (holding) check_val("r_data", instr_data, hold_data);
            check_val("r_inc", 32'(pc_inc), 32'(exp_inc));
            check_val("r_err", 32'(fetch_err), 32'd0);
            if (mem_req) check_val("r_addr", 32'(mem_addr), 32'(pc_addr));
            check_val("r_req_busy", 32'(mem_req && (outstanding || holding)), 32'd0);
            inc_seen = pc_inc;
            if (inc_seen) begin
                n_inc++;
                idle_cycles = 0;
            end else begin
                idle_cycles++;
            end
            check_val("r_stall", 32'(idle_cycles > 150), 32'd0);

            // Transaction model update for this clock edge.
            if (holding && (do_flush || instr_ready)) holding = 1'b0;
            if (outstanding && mem_rvalid) begin
                outstanding = 1'b0;
                if (live && !do_flush) begin
                    holding   = 1'b1;
                    hold_data = pend_data;
                end
                live = 1'b0;
            end else if (outstanding) begin
                if (do_flush) live = 1'b0;
                if (lat > 0) lat--;
            end
            if (mem_gnt) begin
                outstanding = 1'b1;
                live        = 1'b1;
                pend_data   = word_of(pc_addr);
                lat         = $urandom_range(0, 2);
            end

            tick();
            if (do_flush) pc_addr = tgt;
            else if (inc_seen) pc_addr = pc_addr + 8'd4;
        end
        flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; instr_ready = 1'b0;
        check_val("r_total_inc", 32'(n_inc >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
